// File: rtl/led_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_seq_pkg : shared mode encodings, direction constants and seed values |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest pattern supported; callers size-cast the result down to their width.
  localparam int MAX_LEDS = 64;

  function automatic logic [MAX_LEDS-1:0] seed(input mode_e m);
    case (m)
      MODE_CHASE, MODE_BOUNCE: seed = MAX_LEDS'(1);
      default:                 seed = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_seq_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_seq_prescaler : counts 0..STEP_CYCLES-1 while enabled, ticks on last |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module led_seq_prescaler #(
  parameter int STEP_CYCLES = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int              CW   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0]   LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign tick = enable && (r_count == LAST);

  // Clear wins over counting; a disabled counter holds rather than clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= tick ? '0 : r_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | led_sequencer : N-LED chase/bounce/count/blink pattern generator         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS      = 4,
  parameter int STEP_CYCLES = 50
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              dir,
  output logic [N_LEDS-1:0] led,
  output logic              step
);

  mode_e             r_mode;
  logic              r_heading;
  logic [N_LEDS-1:0] r_led;
  logic              r_step;

  logic              w_tick;
  logic              w_mode_chg;
  logic [N_LEDS-1:0] w_seed;
  logic [N_LEDS-1:0] w_next_led;
  logic              w_next_heading;

  assign w_mode_chg = (mode_e'(mode) != r_mode);
  assign w_seed     = N_LEDS'(seed(mode_e'(mode)));

  led_seq_prescaler #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (w_mode_chg),
    .tick   (w_tick)
  );

  always_comb begin
    w_next_led     = r_led;
    w_next_heading = r_heading;
    case (r_mode)
      MODE_CHASE: begin
        // Shift-or rotate also degenerates correctly to "hold" when N_LEDS is 1.
        if (dir == DIR_UP)
          w_next_led = (r_led << 1) | (r_led >> (N_LEDS - 1));
        else
          w_next_led = (r_led >> 1) | (r_led << (N_LEDS - 1));
      end
      MODE_BOUNCE: begin
        if (N_LEDS > 1) begin
          if (r_led[N_LEDS-1]) begin
            w_next_heading = DIR_DOWN;
            w_next_led     = r_led >> 1;
          end else if (r_led[0]) begin
            w_next_heading = DIR_UP;
            w_next_led     = r_led << 1;
          end else if (r_heading == DIR_UP) begin
            w_next_led     = r_led << 1;
          end else begin
            w_next_led     = r_led >> 1;
          end
        end
      end
      MODE_COUNT: begin
        if (dir == DIR_UP)
          w_next_led = r_led + N_LEDS'(1);
        else
          w_next_led = r_led - N_LEDS'(1);
      end
      default: begin
        w_next_led = ~r_led;
      end
    endcase
  end

  // A mode change reloads everything and suppresses any coincident tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode    <= MODE_CHASE;
      r_heading <= DIR_UP;
      r_led     <= N_LEDS'(1);
      r_step    <= 1'b0;
    end else if (w_mode_chg) begin
      r_mode    <= mode_e'(mode);
      r_heading <= DIR_UP;
      r_led     <= w_seed;
      r_step    <= 1'b0;
    end else if (w_tick) begin
      r_heading <= w_next_heading;
      r_led     <= w_next_led;
      r_step    <= 1'b1;
    end else begin
      r_step    <= 1'b0;
    end
  end

  assign led  = r_led;
  assign step = r_step;

endmodule
`default_nettype wire

// File: tb/tb_led_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_led_sequencer : directed self-checking bench for led_sequencer        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] mode;
  logic       dir;
  logic [3:0] led;
  logic       step;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_sequencer #(
    .N_LEDS      (4),
    .STEP_CYCLES (50)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .mode   (mode),
    .dir    (dir),
    .led    (led),
    .step   (step)
  );

  // Advance n rising edges, sampling 1ns after each; count step pulses seen.
  task automatic advance(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (step === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    enable = 1'b0;
    mode   = 2'b00;
    dir    = 1'b0;
    #23;
    checks++;
    if (led !== 4'b0001 || step !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: led=%b step=%b expected led=0001 step=0", led, step);
    end
    enable = 1'b1;
    reset  = 1'b0;
  endtask

  task automatic test_chase_up();
    logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] prev = 4'b0001;
    int p;
    int total = 0;
    for (int i = 0; i < 4; i++) begin
      advance(49, p);
      total += p;
      checks++;
      if (led !== prev) begin
        failures++;
        $display("FAIL chase_up_hold[%0d]: led=%b expected %b", i, led, prev);
      end
      advance(1, p);
      total += p;
      checks++;
      if (led !== exp_seq[i] || step !== 1'b1) begin
        failures++;
        $display("FAIL chase_up_step[%0d]: led=%b step=%b expected led=%b step=1", i, led, step, exp_seq[i]);
      end
      prev = exp_seq[i];
    end
    checks++;
    if (total !== 4) begin
      failures++;
      $display("FAIL chase_up_pulses: got %0d expected 4", total);
    end
  endtask

  task automatic test_chase_down();
    logic [3:0] exp_seq [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    int p;
    dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      advance(49, p);
      checks++;
      if (p !== 0) begin
        failures++;
        $display("FAIL chase_down_quiet[%0d]: pulses=%0d expected 0", i, p);
      end
      advance(1, p);
      checks++;
      if (led !== exp_seq[i] || step !== 1'b1) begin
        failures++;
        $display("FAIL chase_down_step[%0d]: led=%b step=%b expected led=%b step=1", i, led, step, exp_seq[i]);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    int p;
    advance(20, p);
    mode = 2'b01;
    advance(1, p);
    checks++;
    if (led !== 4'b0001 || step !== 1'b0) begin
      failures++;
      $display("FAIL bounce_reload: led=%b step=%b expected led=0001 step=0", led, step);
    end
    for (int i = 0; i < 7; i++) begin
      advance(49, p);
      checks++;
      if (p !== 0) begin
        failures++;
        $display("FAIL bounce_quiet[%0d]: pulses=%0d expected 0", i, p);
      end
      advance(1, p);
      checks++;
      if (led !== exp_seq[i] || step !== 1'b1) begin
        failures++;
        $display("FAIL bounce_step[%0d]: led=%b step=%b expected led=%b step=1", i, led, step, exp_seq[i]);
      end
    end
  endtask

  task automatic test_count();
    logic [3:0] exp_seq [4] = '{4'b1111, 4'b1110, 4'b1111, 4'b0000};
    logic       dir_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    int p;
    mode = 2'b10;
    advance(1, p);
    checks++;
    if (led !== 4'b0000 || step !== 1'b0) begin
      failures++;
      $display("FAIL count_reload: led=%b step=%b expected led=0000 step=0", led, step);
    end
    for (int i = 0; i < 4; i++) begin
      dir = dir_seq[i];
      advance(50, p);
      checks++;
      if (led !== exp_seq[i] || step !== 1'b1 || p !== 1) begin
        failures++;
        $display("FAIL count_step[%0d]: led=%b step=%b pulses=%0d expected led=%b step=1 pulses=1",
                 i, led, step, p, exp_seq[i]);
      end
    end
  endtask

  task automatic test_blink_enable_hold();
    int p;
    mode = 2'b11;
    advance(1, p);
    checks++;
    if (led !== 4'b0000 || step !== 1'b0) begin
      failures++;
      $display("FAIL blink_reload: led=%b step=%b expected led=0000 step=0", led, step);
    end
    advance(20, p);
    enable = 1'b0;
    advance(30, p);
    checks++;
    if (led !== 4'b0000 || p !== 0) begin
      failures++;
      $display("FAIL blink_disabled: led=%b pulses=%0d expected led=0000 pulses=0", led, p);
    end
    enable = 1'b1;
    advance(29, p);
    checks++;
    if (led !== 4'b0000 || p !== 0) begin
      failures++;
      $display("FAIL blink_resume_early: led=%b pulses=%0d expected led=0000 pulses=0", led, p);
    end
    advance(1, p);
    checks++;
    if (led !== 4'b1111 || step !== 1'b1) begin
      failures++;
      $display("FAIL blink_toggle: led=%b step=%b expected led=1111 step=1", led, step);
    end
    advance(50, p);
    checks++;
    if (led !== 4'b0000 || step !== 1'b1) begin
      failures++;
      $display("FAIL blink_toggle2: led=%b step=%b expected led=0000 step=1", led, step);
    end
  endtask

  task automatic test_async_reset();
    int p;
    mode = 2'b10;
    dir  = 1'b0;
    advance(1, p);
    advance(250, p);
    checks++;
    if (led !== 4'b0101 || step !== 1'b1) begin
      failures++;
      $display("FAIL count_to_5: led=%b step=%b expected led=0101 step=1", led, step);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0001 || step !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: led=%b step=%b expected led=0001 step=0", led, step);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    advance(1, p);
    checks++;
    if (led !== 4'b0000 || step !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_reload: led=%b step=%b expected led=0000 step=0", led, step);
    end
    advance(50, p);
    checks++;
    if (led !== 4'b0001 || step !== 1'b1 || p !== 1) begin
      failures++;
      $display("FAIL post_reset_first_step: led=%b step=%b pulses=%0d expected led=0001 step=1 pulses=1",
               led, step, p);
    end
  endtask

  initial begin
    test_reset();
    test_chase_up();
    test_chase_down();
    test_bounce();
    test_count();
    test_blink_enable_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
